// File: rtl/e203_exu_regfile_mp_pkg.sv
// -----------------------------------------------------------------------------
// e203_exu_regfile_mp_pkg
// Shared core defines for the multi-port register file. The module parameter
// defaults come from these values. The package also holds a helper that says
// whether an index names a real, writable architectural register.
// -----------------------------------------------------------------------------
package e203_exu_regfile_mp_pkg;

  localparam int E203_XLEN        = 32;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_RFREG_NUM   = 32;
  localparam int E203_RF_NRD      = 2;
  localparam int E203_RF_NWR      = 2;

  // x0 and indices beyond the implemented file (RV32E) hold no state.
  function automatic bit rf_idx_legal(int idx, int reg_num);
    return (idx != 0) && (idx < reg_num);
  endfunction

endpackage

// File: rtl/e203_exu_regfile_mp_if.sv
// -----------------------------------------------------------------------------
// e203_exu_regfile_mp_if
// Bundles the register file's bus signals: read ports, write ports and the
// scoreboard-set request.
//   master : dispatch/writeback side (drives indices, write data, sb_set)
//   slave  : the register file (returns read data and busy bits)
// Fields: rd_idx/rd_dat/rd_busy   packed per read port
//         wr_en/wr_idx/wr_dat/wr_clr packed per write port
//         sb_set/sb_idx           mark one register busy
// -----------------------------------------------------------------------------
interface e203_exu_regfile_mp_if
  import e203_exu_regfile_mp_pkg::*;
#(
  parameter int XLEN    = E203_XLEN,
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int NRD     = E203_RF_NRD,
  parameter int NWR     = E203_RF_NWR
);

  logic [NRD*RFIDX_W-1:0] rd_idx;
  logic [NRD*XLEN-1:0]    rd_dat;
  logic [NRD-1:0]         rd_busy;

  logic [NWR-1:0]         wr_en;
  logic [NWR*RFIDX_W-1:0] wr_idx;
  logic [NWR*XLEN-1:0]    wr_dat;
  logic [NWR-1:0]         wr_clr;

  logic                   sb_set;
  logic [RFIDX_W-1:0]     sb_idx;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_dat, wr_clr, sb_set, sb_idx,
    input  rd_dat, rd_busy
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_dat, wr_clr, sb_set, sb_idx,
    output rd_dat, rd_busy
  );

endinterface

// File: rtl/e203_exu_regfile_wsel.sv
// -----------------------------------------------------------------------------
// e203_exu_regfile_wsel
// Write-select priority encoder for a single register index. It finds the
// write ports that target reg_idx_i. The highest-numbered enabled port wins.
//   wr_en_i/wr_idx_i/wr_dat_i/wr_clr_i : packed write-port bus
//   reg_idx_i                           : index being matched
//   hit_o   : some enabled port targets reg_idx_i
//   dat_o   : winning port's data (0 when no hit)
//   clr_o   : winning port's busy-clear flag (0 when no hit)
// The same encoder is used for register updates and for read-port bypass.
// -----------------------------------------------------------------------------
module e203_exu_regfile_wsel
  import e203_exu_regfile_mp_pkg::*;
#(
  parameter int XLEN    = E203_XLEN,
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int NWR     = E203_RF_NWR
) (
  input  logic [NWR-1:0]         wr_en_i,
  input  logic [NWR*RFIDX_W-1:0] wr_idx_i,
  input  logic [NWR*XLEN-1:0]    wr_dat_i,
  input  logic [NWR-1:0]         wr_clr_i,
  input  logic [RFIDX_W-1:0]     reg_idx_i,
  output logic                   hit_o,
  output logic [XLEN-1:0]        dat_o,
  output logic                   clr_o
);

  // NOTE: every output is given a default before the loop, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    hit_o = 1'b0;
    dat_o = '0;
    clr_o = 1'b0;
    // Ascending scan: a later (higher) port overrides an earlier match.
    for (int w = 0; w < NWR; w++) begin
      if (wr_en_i[w] && (wr_idx_i[w*RFIDX_W +: RFIDX_W] == reg_idx_i)) begin
        hit_o = 1'b1;
        dat_o = wr_dat_i[w*XLEN +: XLEN];
        clr_o = wr_clr_i[w];
      end
    end
  end

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// -----------------------------------------------------------------------------
// sirv_gnrl_dfflr
// General load-enable flop with asynchronous active-low reset to zero.
//   lden  : load enable
//   dnxt  : next value, loaded when lden is high
//   qout  : stored value
//   clk, rst_n
// -----------------------------------------------------------------------------
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);

  logic [DW-1:0] q_q;

  // NOTE: state updates use <= so every flop samples pre-edge values;
  // blocking assignments here would make results depend on process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (lden) begin
      q_q <= dnxt;
    end
  end

  assign qout = q_q;

endmodule

// File: rtl/e203_exu_regfile_mp.sv
// -----------------------------------------------------------------------------
// e203_exu_regfile_mp
// Parametrised EXU general-purpose register file. It has NRD combinational
// read ports and NWR write ports. It supports optional write-to-read bypass
// and keeps a per-register busy scoreboard for long-latency writebacks.
//   clk, rst_n : clock, asynchronous active-low reset
//   test_mode  : DFT strap, no functional effect
//   rf         : slave side of the read/write/scoreboard bus
//   busy_vec   : registered busy bits, bit 0 always 0
//   x1_r       : stored (never bypassed) x1, for IFU jalr prediction
// The array is sized to the full index space. Unimplemented indices (x0, and
// x16..x31 for RV32E) are constant zero, so reads need no range check.
// -----------------------------------------------------------------------------
module e203_exu_regfile_mp
  import e203_exu_regfile_mp_pkg::*;
#(
  parameter int XLEN      = E203_XLEN,
  parameter int RFREG_NUM = E203_RFREG_NUM,
  parameter int RFIDX_W   = E203_RFIDX_WIDTH,
  parameter int NRD       = E203_RF_NRD,
  parameter int NWR       = E203_RF_NWR,
  parameter int BYPASS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_mode,
  e203_exu_regfile_mp_if.slave  rf,
  output logic [RFREG_NUM-1:0]  busy_vec,
  output logic [XLEN-1:0]       x1_r
);

  localparam int IDX_SPAN = 1 << RFIDX_W;

  logic [XLEN-1:0]     rf_q [IDX_SPAN];
  logic [IDX_SPAN-1:0] busy_q;
  logic [IDX_SPAN-1:0] reg_ok;

  // test_mode only exists for clock-gate compatibility.
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  // ---------------------------------------------------------------------------
  // Storage and scoreboard, one slice per index
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < IDX_SPAN; r++) begin : g_reg
    if (rf_idx_legal(r, RFREG_NUM)) begin : g_live
      localparam logic [RFIDX_W-1:0] REG_IDX = RFIDX_W'(r);

      logic            wr_hit;
      logic [XLEN-1:0] wr_dat;
      logic            wr_clr;
      logic            sb_hit;
      logic            busy_ld;

      e203_exu_regfile_wsel #(
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W),
        .NWR     (NWR)
      ) u_wsel (
        .wr_en_i   (rf.wr_en),
        .wr_idx_i  (rf.wr_idx),
        .wr_dat_i  (rf.wr_dat),
        .wr_clr_i  (rf.wr_clr),
        .reg_idx_i (REG_IDX),
        .hit_o     (wr_hit),
        .dat_o     (wr_dat),
        .clr_o     (wr_clr)
      );

      // NOTE: each register is reset because zero after reset is
      // architecturally visible; this file cannot be mapped to an
      // unreset RAM macro.
      sirv_gnrl_dfflr #(.DW(XLEN)) u_dat (
        .lden  (wr_hit),
        .dnxt  (wr_dat),
        .qout  (rf_q[r]),
        .clk   (clk),
        .rst_n (rst_n)
      );

      // Set beats clear: a set loads 1; otherwise a clearing write loads 0.
      assign sb_hit  = rf.sb_set & (rf.sb_idx == REG_IDX);
      assign busy_ld = sb_hit | (wr_hit & wr_clr);

      sirv_gnrl_dfflr #(.DW(1)) u_busy (
        .lden  (busy_ld),
        .dnxt  (sb_hit),
        .qout  (busy_q[r]),
        .clk   (clk),
        .rst_n (rst_n)
      );

      assign reg_ok[r] = 1'b1;
    end else begin : g_tie
      assign rf_q[r]   = '0;
      assign busy_q[r] = 1'b0;
      assign reg_ok[r] = 1'b0;
    end
  end

  assign busy_vec = busy_q[RFREG_NUM-1:0];
  assign x1_r     = rf_q[1];

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [RFIDX_W-1:0] idx;
    assign idx = rf.rd_idx[p*RFIDX_W +: RFIDX_W];

    // Busy is the registered bit only; same-cycle set/clear is not forwarded.
    assign rf.rd_busy[p] = busy_q[idx];

    if (BYPASS != 0) begin : g_byp
      logic            byp_hit;
      logic [XLEN-1:0] byp_dat;
      logic            unused_byp_clr;

      e203_exu_regfile_wsel #(
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W),
        .NWR     (NWR)
      ) u_byp (
        .wr_en_i   (rf.wr_en),
        .wr_idx_i  (rf.wr_idx),
        .wr_dat_i  (rf.wr_dat),
        .wr_clr_i  (rf.wr_clr),
        .reg_idx_i (idx),
        .hit_o     (byp_hit),
        .dat_o     (byp_dat),
        .clr_o     (unused_byp_clr)
      );

      // Dropped writes (x0, out-of-range) must not leak through the bypass.
      assign rf.rd_dat[p*XLEN +: XLEN] = (byp_hit && reg_ok[idx]) ? byp_dat : rf_q[idx];
    end else begin : g_nobyp
      assign rf.rd_dat[p*XLEN +: XLEN] = rf_q[idx];
    end
  end

endmodule

// File: tb/tb_e203_exu_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_e203_exu_regfile_mp
// Drives one stimulus stream into two register files: an RV32I file with
// bypass, and an RV32E file without bypass. A behavioural model of both files
// is checked on every falling edge. Directed steps add literal expectations.
// -----------------------------------------------------------------------------
module tb_e203_exu_regfile_mp;

  localparam int XLEN = 32;
  localparam int IW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic test_mode;
  always #5 clk = ~clk;

  logic [NRD*IW-1:0]   rd_idx;
  logic [NWR-1:0]      wr_en;
  logic [NWR*IW-1:0]   wr_idx;
  logic [NWR*XLEN-1:0] wr_dat;
  logic [NWR-1:0]      wr_clr;
  logic                sb_set;
  logic [IW-1:0]       sb_idx;

  logic [31:0] busy_vec_a;
  logic [15:0] busy_vec_e;
  logic [31:0] x1_a;
  logic [31:0] x1_e;

  e203_exu_regfile_mp_if #(.XLEN(XLEN), .RFIDX_W(IW), .NRD(NRD), .NWR(NWR)) if_a ();
  e203_exu_regfile_mp_if #(.XLEN(XLEN), .RFIDX_W(IW), .NRD(NRD), .NWR(NWR)) if_e ();

  assign if_a.rd_idx = rd_idx;
  assign if_a.wr_en  = wr_en;
  assign if_a.wr_idx = wr_idx;
  assign if_a.wr_dat = wr_dat;
  assign if_a.wr_clr = wr_clr;
  assign if_a.sb_set = sb_set;
  assign if_a.sb_idx = sb_idx;

  assign if_e.rd_idx = rd_idx;
  assign if_e.wr_en  = wr_en;
  assign if_e.wr_idx = wr_idx;
  assign if_e.wr_dat = wr_dat;
  assign if_e.wr_clr = wr_clr;
  assign if_e.sb_set = sb_set;
  assign if_e.sb_idx = sb_idx;

  e203_exu_regfile_mp #(
    .XLEN(XLEN), .RFREG_NUM(32), .RFIDX_W(IW), .NRD(NRD), .NWR(NWR), .BYPASS(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_mode (test_mode),
    .rf        (if_a),
    .busy_vec  (busy_vec_a),
    .x1_r      (x1_a)
  );

  e203_exu_regfile_mp #(
    .XLEN(XLEN), .RFREG_NUM(16), .RFIDX_W(IW), .NRD(NRD), .NWR(NWR), .BYPASS(0)
  ) dut_e (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_mode (test_mode),
    .rf        (if_e),
    .busy_vec  (busy_vec_e),
    .x1_r      (x1_e)
  );

  // ---------------------------------------------------------------------------
  // Reference model: index 0 = RV32I/bypass, index 1 = RV32E/no bypass
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem  [2][32];
  bit          m_busy [2][32];
  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit in_reset = 1'b1;

  function automatic int nreg(int c);
    return (c == 0) ? 32 : 16;
  endfunction

  function automatic bit legal(int c, int i);
    return (i != 0) && (i < nreg(c));
  endfunction

  function automatic logic [31:0] exp_rd(int c, int i);
    logic [31:0] v;
    if (!legal(c, i)) return 32'h0;
    v = m_mem[c][i];
    if (c == 0) begin
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && int'(wr_idx[w*IW +: IW]) == i) v = wr_dat[w*XLEN +: XLEN];
    end
    return v;
  endfunction

  function automatic bit exp_busy(int c, int i);
    return legal(c, i) ? m_busy[c][i] : 1'b0;
  endfunction

  function automatic logic [31:0] exp_vec(int c);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i] = exp_busy(c, i);
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_mem[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  // Applies one clock edge's worth of architectural effects.
  task automatic model_step();
    bit hit [32];
    bit clr [32];
    int i;
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 32; r++) begin
        hit[r] = 1'b0;
        clr[r] = 1'b0;
      end
      for (int w = 0; w < NWR; w++) begin
        i = int'(wr_idx[w*IW +: IW]);
        if (wr_en[w] && legal(c, i)) begin
          m_mem[c][i] = wr_dat[w*XLEN +: XLEN];
          hit[i] = 1'b1;
          clr[i] = wr_clr[w];
        end
      end
      for (int r = 0; r < 32; r++)
        if (hit[r] && clr[r]) m_busy[c][r] = 1'b0;
      i = int'(sb_idx);
      if (sb_set && legal(c, i)) m_busy[c][i] = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Cycle compare against the model
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NRD; p++) begin
        int i;
        i = int'(rd_idx[p*IW +: IW]);
        check($sformatf("a_rd_dat%0d", p), if_a.rd_dat[p*XLEN +: XLEN], exp_rd(0, i));
        check($sformatf("e_rd_dat%0d", p), if_e.rd_dat[p*XLEN +: XLEN], exp_rd(1, i));
        check($sformatf("a_rd_busy%0d", p), {31'b0, if_a.rd_busy[p]}, {31'b0, exp_busy(0, i)});
        check($sformatf("e_rd_busy%0d", p), {31'b0, if_e.rd_busy[p]}, {31'b0, exp_busy(1, i)});
      end
      check("a_busy_vec", busy_vec_a, exp_vec(0));
      check("e_busy_vec", {16'b0, busy_vec_e}, exp_vec(1));
      check("a_x1_r", x1_a, m_mem[0][1]);
      check("e_x1_r", x1_e, m_mem[1][1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    if (!in_reset) model_step();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en  = '0;
    wr_idx = '0;
    wr_dat = '0;
    wr_clr = '0;
    sb_set = 1'b0;
    sb_idx = '0;
  endtask

  task automatic set_wr(input int w, input logic [IW-1:0] idx, input logic [31:0] dat, input logic clr);
    wr_en[w]              = 1'b1;
    wr_idx[w*IW +: IW]    = idx;
    wr_dat[w*XLEN +: XLEN] = dat;
    wr_clr[w]             = clr;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] rand_idx();
    if ($urandom_range(0, 3) == 0) return IW'($urandom_range(0, 31));
    return IW'($urandom_range(0, 11));
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_mode = 1'b0;
    rst_n     = 1'b0;
    rd_idx    = '0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    chk_en   = 1'b1;

    // Reset state: sweep every index on both ports.
    for (int i = 0; i < 32; i++) begin
      tick();
      rd_idx = {IW'(31 - i), IW'(i)};
    end
    sample();
    check("lit_reset_busy_vec", busy_vec_a, 32'h0);
    check("lit_reset_x1", x1_a, 32'h0);

    // Single write with same-cycle read of the target.
    tick();
    set_wr(0, 5'd5, 32'hDEADBEEF, 1'b0);
    rd_idx = {5'd0, 5'd5};
    sample();
    check("lit_bypass_same_cycle", if_a.rd_dat[31:0], 32'hDEADBEEF);
    check("lit_nobypass_old", if_e.rd_dat[31:0], 32'h0);
    tick();
    idle_inputs();
    sample();
    check("lit_nobypass_next", if_e.rd_dat[31:0], 32'hDEADBEEF);

    // Both ports hit x7: port 1 wins.
    tick();
    set_wr(0, 5'd7, 32'h11, 1'b0);
    set_wr(1, 5'd7, 32'h22, 1'b0);
    rd_idx = {5'd0, 5'd7};
    sample();
    check("lit_prio_bypass", if_a.rd_dat[31:0], 32'h22);
    tick();
    idle_inputs();
    sample();
    check("lit_prio_stored", if_e.rd_dat[31:0], 32'h22);
    // x0 write dropped.
    tick();
    set_wr(0, 5'd0, 32'hFFFFFFFF, 1'b0);
    rd_idx = {5'd0, 5'd0};
    sample();
    check("lit_x0_bypass", if_a.rd_dat[31:0], 32'h0);
    tick();
    idle_inputs();
    sample();
    check("lit_x0_stored", if_a.rd_dat[31:0], 32'h0);

    // Scoreboard set / hold / clear on x9.
    tick();
    sb_set = 1'b1;
    sb_idx = 5'd9;
    rd_idx = {5'd9, 5'd0};
    sample();
    check("lit_busy_not_bypassed", {31'b0, if_a.rd_busy[1]}, 32'h0);
    tick();
    idle_inputs();
    sample();
    check("lit_busy9_set", {31'b0, busy_vec_a[9]}, 32'h1);
    check("lit_rd_busy9", {31'b0, if_e.rd_busy[1]}, 32'h1);
    tick();
    set_wr(1, 5'd9, 32'h99, 1'b0);
    tick();
    idle_inputs();
    sample();
    check("lit_busy9_noclr", {31'b0, busy_vec_a[9]}, 32'h1);
    tick();
    set_wr(0, 5'd9, 32'h999, 1'b1);
    tick();
    idle_inputs();
    sample();
    check("lit_busy9_clr", {31'b0, busy_vec_a[9]}, 32'h0);
    check("lit_x9_data", if_e.rd_dat[63:32], 32'h999);

    // Set beats clear on x3.
    tick();
    sb_set = 1'b1;
    sb_idx = 5'd3;
    tick();
    set_wr(0, 5'd3, 32'h33, 1'b1);
    rd_idx = {5'd0, 5'd3};
    tick();
    idle_inputs();
    sample();
    check("lit_set_beats_clr", {31'b0, busy_vec_a[3]}, 32'h1);
    check("lit_x3_written", if_e.rd_dat[31:0], 32'h33);

    // Out-of-range write on the RV32E file.
    tick();
    set_wr(0, 5'd20, 32'h55, 1'b0);
    sb_set = 1'b1;
    sb_idx = 5'd20;
    rd_idx = {5'd20, 5'd20};
    tick();
    idle_inputs();
    sample();
    check("lit_e_oor_read", if_e.rd_dat[31:0], 32'h0);
    check("lit_e_oor_busy", {31'b0, if_e.rd_busy[0]}, 32'h0);
    check("lit_a_x20", if_a.rd_dat[31:0], 32'h55);

    // Randomised traffic.
    repeat (3000) begin
      tick();
      idle_inputs();
      for (int w = 0; w < NWR; w++)
        if ($urandom_range(0, 2) != 0)
          set_wr(w, rand_idx(), $urandom(), 1'($urandom_range(0, 1)));
      sb_set = ($urandom_range(0, 3) == 0);
      sb_idx = rand_idx();
      rd_idx = {rand_idx(), rand_idx()};
    end

    // Asynchronous reset in the middle of a write.
    tick();
    idle_inputs();
    set_wr(0, 5'd1, 32'h1111, 1'b0);
    set_wr(1, 5'd4, 32'h4444, 1'b0);
    sb_set = 1'b1;
    sb_idx = 5'd4;
    tick();
    idle_inputs();
    rd_idx = {5'd1, 5'd4};
    sample();
    check("lit_pre_reset_x1", x1_a, 32'h1111);
    check("lit_pre_reset_busy4", {31'b0, busy_vec_e[4]}, 32'h1);
    tick();
    set_wr(0, 5'd1, 32'hABCD, 1'b0);
    set_wr(1, 5'd2, 32'h2222, 1'b1);
    @(negedge clk);
    #1;
    chk_en   = 1'b0;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    model_reset();
    #1;
    check("lit_rst_busy_a", busy_vec_a, 32'h0);
    check("lit_rst_busy_e", {16'b0, busy_vec_e}, 32'h0);
    check("lit_rst_x1_a", x1_a, 32'h0);
    check("lit_rst_x1_e", x1_e, 32'h0);
    check("lit_rst_a_rd0", if_a.rd_dat[31:0], 32'h0);
    check("lit_rst_e_rd0", if_e.rd_dat[31:0], 32'h0);
    check("lit_rst_e_rd1", if_e.rd_dat[63:32], 32'h0);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    chk_en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      rd_idx = {IW'(i + 8), IW'(i)};
    end
    sample();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
